// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared types and constants for the RS(255,247) receive path
package rs_pkg;

    localparam int RS_N  = 255;
    localparam int RS_K  = 247;
    localparam int RS_T  = 4;
    localparam int SYM_W = 8;

    typedef struct packed {
        logic                        fail;
        logic [2:0]                  num;
        logic [RS_T-1:0][SYM_W-1:0]  el;
        logic [RS_T-1:0][SYM_W-1:0]  ev;
    } rs_result_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_RUN   = 2'd1,
        R_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rs_frame_ram.sv
// rtl/rs_frame_ram.sv - simple dual-port frame RAM, registered read, bank = address MSB
module rs_frame_ram
    import rs_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = SYM_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rs_corrector.sv
// rtl/rs_corrector.sv - ping-pong codeword buffer that applies rs_decoder corrections
module rs_corrector
    import rs_pkg::*;
#(
    parameter int N            = RS_N,
    parameter int K            = RS_K,
    parameter bit STRIP_PARITY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_val,
    input  logic       din_sop,
    input  logic       din_eop,
    input  logic [7:0] din,
    input  logic       dec_done,
    input  logic       dec_fail,
    input  logic [2:0] error_num,
    input  logic [7:0] el1,
    input  logic [7:0] el2,
    input  logic [7:0] el3,
    input  logic [7:0] el4,
    input  logic [7:0] ev1,
    input  logic [7:0] ev2,
    input  logic [7:0] ev3,
    input  logic [7:0] ev4,
    output logic       dout_val,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic [7:0] dout,
    output logic       dout_uncorr,
    output logic       overflow
);

    localparam int         L        = STRIP_PARITY ? K : N;
    localparam logic [7:0] LAST_IDX = 8'(L - 1);
    localparam logic [8:0] N9       = 9'(N);

    // write side
    logic       wr_bank;
    logic       wr_active;
    logic       wr_drop;
    logic [8:0] wr_cnt;
    logic [1:0] bank_full;
    logic [1:0] free_vec;
    logic [1:0] full_eff;
    logic       sop_in;
    logic       drop_now;
    logic       frame_end;
    logic       frame_dropped;
    logic       mark_full;
    logic       ram_we;
    logic [8:0] ram_waddr;

    // read side
    rd_state_t  state;
    rd_state_t  state_n;
    logic       rd_bank;
    logic [7:0] rd_cnt;
    logic       ram_re;
    logic       res_pop;
    logic       bank_free;
    logic [7:0] ram_q;

    // result path
    logic [3:0] tag_q;
    logic [3:0] tag_q_n;
    logic [2:0] tag_cnt;
    logic [2:0] tag_cnt_n;
    logic       head_drop;
    logic       res_push_req;
    logic       res_push;
    logic       res_full;
    logic       res_wp;
    logic       res_rp;
    logic [1:0] res_cnt;
    rs_result_t res_in;
    rs_result_t res_mem [2];
    rs_result_t work;

    // correction pipeline
    logic       s1_val;
    logic       s1_sop;
    logic       s1_eop;
    logic [7:0] s1_idx;
    logic [7:0] corr_mask;
    logic [8:0] loc;

    assign free_vec  = bank_free ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign full_eff  = bank_full & ~free_vec;
    assign sop_in    = din_val & din_sop;
    // the write bank always holds the older buffered frame, so it being full means both are
    assign drop_now  = sop_in & full_eff[wr_bank] & ~rst;
    assign overflow  = drop_now;
    assign ram_we    = din_val & (sop_in ? ~drop_now : (wr_active & ~wr_drop & (wr_cnt < N9)));
    assign ram_waddr = {wr_bank, sop_in ? 8'd0 : wr_cnt[7:0]};
    assign frame_end     = din_val & din_eop & (sop_in | wr_active);
    assign frame_dropped = sop_in ? drop_now : wr_drop;
    assign mark_full     = frame_end & ~frame_dropped;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            wr_active <= 1'b0;
            wr_drop   <= 1'b0;
            wr_cnt    <= '0;
            bank_full <= '0;
        end else begin
            if (sop_in) begin
                wr_active <= 1'b1;
                wr_drop   <= drop_now;
                wr_cnt    <= 9'd1;
            end else if (ram_we) begin
                wr_cnt <= wr_cnt + 9'd1;
            end
            if (frame_end) begin
                wr_active <= 1'b0;
                if (!frame_dropped) begin
                    wr_bank <= ~wr_bank;
                end
            end
            bank_full <= full_eff | (mark_full ? (wr_bank ? 2'b10 : 2'b01) : 2'b00);
        end
    end

    rs_frame_ram #(
        .ADDR_W (9),
        .DATA_W (SYM_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (din),
        .re    (ram_re),
        .raddr ({rd_bank, rd_cnt}),
        .rdata (ram_q)
    );

    // one tag per completed input frame, so results of dropped frames can be discarded in order
    assign head_drop    = (tag_cnt != 3'd0) & tag_q[0];
    assign res_push_req = dec_done & ~head_drop;
    assign res_full     = (res_cnt == 2'd2);
    assign res_push     = res_push_req & ~res_full;

    always_comb begin
        tag_q_n   = tag_q;
        tag_cnt_n = tag_cnt;
        if (dec_done && tag_cnt != 3'd0) begin
            tag_q_n   = tag_q >> 1;
            tag_cnt_n = tag_cnt - 3'd1;
        end
        if (frame_end && tag_cnt_n < 3'd4) begin
            tag_q_n[tag_cnt_n[1:0]] = frame_dropped;
            tag_cnt_n               = tag_cnt_n + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            tag_cnt <= '0;
        end else begin
            tag_q   <= tag_q_n;
            tag_cnt <= tag_cnt_n;
        end
    end

    always_comb begin
        res_in.fail = dec_fail | (error_num > 3'd4);
        res_in.num  = error_num;
        res_in.el   = {el4, el3, el2, el1};
        res_in.ev   = {ev4, ev3, ev2, ev1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_wp  <= 1'b0;
            res_rp  <= 1'b0;
            res_cnt <= '0;
            work    <= '0;
        end else begin
            if (res_push) begin
                res_mem[res_wp] <= res_in;
                res_wp          <= ~res_wp;
            end
            if (res_pop) begin
                work   <= res_mem[res_rp];
                res_rp <= ~res_rp;
            end
            res_cnt <= res_cnt + 2'(res_push) - 2'(res_pop);
        end
    end

    res_overrun_a: assert property (@(posedge clk) disable iff (rst) !(res_push_req && res_full));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= R_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            R_IDLE:  if (bank_full[rd_bank] && res_cnt != 2'd0) state_n = R_RUN;
            R_RUN:   if (rd_cnt == LAST_IDX) state_n = R_DRAIN;
            R_DRAIN: state_n = R_IDLE;
            default: state_n = R_IDLE;
        endcase
    end

    always_comb begin
        ram_re    = (state == R_RUN);
        res_pop   = (state == R_IDLE) && (state_n == R_RUN);
        bank_free = (state == R_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            rd_cnt <= ram_re ? rd_cnt + 8'd1 : 8'd0;
            if (bank_free) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_val <= 1'b0;
            s1_sop <= 1'b0;
            s1_eop <= 1'b0;
            s1_idx <= '0;
        end else begin
            s1_val <= ram_re;
            s1_sop <= ram_re & (rd_cnt == 8'd0);
            s1_eop <= ram_re & (rd_cnt == LAST_IDX);
            s1_idx <= rd_cnt;
        end
    end

    // location el means x^el, i.e. stream index N-1-el; a borrow in loc marks it out of range
    always_comb begin
        corr_mask = '0;
        loc       = '0;
        for (int i = 0; i < RS_T; i++) begin
            loc = 9'(N - 1) - {1'b0, work.el[i]};
            if (!work.fail && i < int'(work.num) && !loc[8] && loc[7:0] == s1_idx) begin
                corr_mask = corr_mask ^ work.ev[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_val    <= 1'b0;
            dout_sop    <= 1'b0;
            dout_eop    <= 1'b0;
            dout        <= '0;
            dout_uncorr <= 1'b0;
        end else begin
            dout_val    <= s1_val;
            dout_sop    <= s1_sop;
            dout_eop    <= s1_eop;
            dout        <= s1_val ? (ram_q ^ corr_mask) : 8'd0;
            dout_uncorr <= s1_val & work.fail;
        end
    end

endmodule

// File: tb/tb_rs_corrector.sv
// tb/tb_rs_corrector.sv - scoreboard bench for rs_corrector, both STRIP_PARITY settings
module tb_rs_corrector;

    typedef struct packed {
        logic              fail;
        logic [254:0][7:0] data;
    } exp_t;

    typedef struct packed {
        logic [31:0]     due;
        logic            fail;
        logic [2:0]      num;
        logic [3:0][7:0] el;
        logic [3:0][7:0] ev;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_val = 1'b0;
    logic       din_sop = 1'b0;
    logic       din_eop = 1'b0;
    logic [7:0] din = 8'd0;
    logic       dec_done = 1'b0;
    logic       dec_fail = 1'b0;
    logic [2:0] error_num = 3'd0;
    logic [7:0] el1 = 8'd0, el2 = 8'd0, el3 = 8'd0, el4 = 8'd0;
    logic [7:0] ev1 = 8'd0, ev2 = 8'd0, ev3 = 8'd0, ev4 = 8'd0;
    logic [1:0] dv, ds, de, du, ovf;
    logic [7:0] dt [2];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   exp_ovf = 0;
    int   ovf_seen [2];
    int   fidx [2];
    int   bidx [2];
    exp_t exp_q [$];
    res_t sched [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rs_corrector #(.STRIP_PARITY(1'b1)) u_strip (
        .clk(clk), .rst(rst), .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop), .din(din),
        .dec_done(dec_done), .dec_fail(dec_fail), .error_num(error_num),
        .el1(el1), .el2(el2), .el3(el3), .el4(el4), .ev1(ev1), .ev2(ev2), .ev3(ev3), .ev4(ev4),
        .dout_val(dv[0]), .dout_sop(ds[0]), .dout_eop(de[0]), .dout(dt[0]),
        .dout_uncorr(du[0]), .overflow(ovf[0])
    );

    rs_corrector #(.STRIP_PARITY(1'b0)) u_full (
        .clk(clk), .rst(rst), .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop), .din(din),
        .dec_done(dec_done), .dec_fail(dec_fail), .error_num(error_num),
        .el1(el1), .el2(el2), .el3(el3), .el4(el4), .ev1(ev1), .ev2(ev2), .ev3(ev3), .ev4(ev4),
        .dout_val(dv[1]), .dout_sop(ds[1]), .dout_eop(de[1]), .dout(dt[1]),
        .dout_uncorr(du[1]), .overflow(ovf[1])
    );

    function automatic int out_len(input int u);
        return (u == 0) ? 247 : 255;
    endfunction

    // reference: apply each listed error value at stream index 254-el, unless the frame failed
    function automatic exp_t model(input logic [254:0][7:0] d, input res_t r);
        exp_t e;
        int   pos;
        e.data = d;
        e.fail = r.fail || (r.num > 3'd4);
        if (!e.fail) begin
            for (int i = 0; i < int'(r.num); i++) begin
                pos = 254 - int'(r.el[i]);
                if (pos >= 0) e.data[pos] = e.data[pos] ^ r.ev[i];
            end
        end
        return e;
    endfunction

    function automatic res_t mk_res(input logic fail, input logic [2:0] num,
                                    input logic [3:0][7:0] el, input logic [3:0][7:0] ev);
        res_t r;
        r.due  = 32'd0;
        r.fail = fail;
        r.num  = num;
        r.el   = el;
        r.ev   = ev;
        return r;
    endfunction

    function automatic logic [254:0][7:0] rand_frame();
        logic [254:0][7:0] d;
        for (int i = 0; i < 255; i++) d[i] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic send_frame(input logic [254:0][7:0] d, input res_t r, input int delay, input bit drop);
        res_t rr;
        for (int i = 0; i < 255; i++) begin
            din_val = 1'b1;
            din_sop = (i == 0);
            din_eop = (i == 254);
            din     = d[i];
            if (i == 0 && drop) exp_ovf++;
            step();
        end
        din_val = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        din     = 8'd0;
        rr      = r;
        rr.due  = 32'(cyc + delay);
        sched.push_back(rr);
        if (!drop) exp_q.push_back(model(d, r));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && (sched.size() != 0 || fidx[0] != exp_q.size() || fidx[1] != exp_q.size())) begin
            step();
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_pending(input int budget);
        int n = 0;
        while (n < budget && (fidx[0] + 1 < exp_q.size() || fidx[1] + 1 < exp_q.size())) begin
            step();
            n++;
        end
        check("slot_in_budget", 32'(n < budget), 32'd1);
    endtask

    // decoder stand-in: delivers queued results in frame order once they fall due
    initial begin
        res_t r;
        forever begin
            step();
            dec_done = 1'b0;
            if (sched.size() != 0 && int'(sched[0].due) <= cyc) begin
                r         = sched.pop_front();
                dec_done  = 1'b1;
                dec_fail  = r.fail;
                error_num = r.num;
                {el4, el3, el2, el1} = r.el;
                {ev4, ev3, ev2, ev1} = r.ev;
            end
        end
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            ovf_seen[u] = 0;
            fidx[u]     = 0;
            bidx[u]     = 0;
        end
    end

    always @(negedge clk) begin
        exp_t        e;
        logic [10:0] act;
        logic [10:0] want;
        if (!rst) begin
            for (int u = 0; u < 2; u++) begin
                if (ovf[u]) begin
                    ovf_seen[u]++;
                    tests++;
                    if (!(din_val && din_sop)) begin
                        fails++;
                        $display("FAIL overflow_on_sop u%0d: got val=%0b sop=%0b want 1 1", u, din_val, din_sop);
                    end
                end
                if (dv[u]) begin
                    tests++;
                    if (fidx[u] >= exp_q.size()) begin
                        fails++;
                        $display("FAIL unexpected_byte u%0d: got %h want no output", u, dt[u]);
                    end else begin
                        e    = exp_q[fidx[u]];
                        act  = {dt[u], ds[u], de[u], du[u]};
                        want = {e.data[bidx[u]], bidx[u] == 0, bidx[u] == out_len(u) - 1, e.fail};
                        if (act !== want) begin
                            fails++;
                            $display("FAIL byte u%0d frame %0d idx %0d: got {d,sop,eop,unc}=%h want %h",
                                     u, fidx[u], bidx[u], act, want);
                        end
                        bidx[u]++;
                        if (bidx[u] == out_len(u)) begin
                            bidx[u] = 0;
                            fidx[u]++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [254:0][7:0] d;
        res_t              r;
        int                n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset_outputs_u%0d", u),
                  32'({dv[u], ds[u], de[u], du[u], ovf[u], dt[u]}), 32'd0);
        end
        check("reset_banks_strip", 32'(u_strip.bank_full), 32'd0);
        check("reset_banks_full", 32'(u_full.bank_full), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) step();

        send_frame(rand_frame(), mk_res(1'b0, 3'd0, '0, '0), 20, 1'b0);
        wait_idle(2000);

        send_frame(rand_frame(), mk_res(1'b0, 3'd4, {8'd0, 8'd8, 8'd200, 8'd254},
                                        {8'h80, 8'hFF, 8'h5A, 8'h01}), 40, 1'b0);
        wait_idle(2000);

        r = mk_res(1'b1, 3'd3, {8'd0, 8'd30, 8'd20, 8'd10}, {8'h00, 8'h11, 8'h22, 8'h33});
        send_frame(rand_frame(), r, 10, 1'b0);
        wait_idle(2000);

        send_frame(rand_frame(), mk_res(1'b0, 3'd2, {8'd0, 8'd0, 8'd10, 8'd10},
                                        {8'h00, 8'h00, 8'hF0, 8'h0F}), 15, 1'b0);
        wait_idle(2000);

        send_frame(rand_frame(), mk_res(1'b0, 3'd1, {8'd0, 8'd0, 8'd0, 8'd100}, {8'd0, 8'd0, 8'd0, 8'h3C}), 300, 1'b0);
        send_frame(rand_frame(), mk_res(1'b0, 3'd1, {8'd0, 8'd0, 8'd0, 8'd5}, {8'd0, 8'd0, 8'd0, 8'hC3}), 300, 1'b0);
        send_frame(rand_frame(), mk_res(1'b0, 3'd1, {8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd0, 8'h99}), 300, 1'b1);
        wait_idle(4000);

        send_frame(rand_frame(), mk_res(1'b0, 3'd0, '0, '0), 5, 1'b0);
        n = 0;
        while (n < 2000 && bidx[0] != 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_byte_100", 32'(n < 2000), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sched.delete();
        for (int u = 0; u < 2; u++) begin
            fidx[u] = exp_q.size();
            bidx[u] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check("rst_dout_val", 32'(dv), 32'd0);
        check("rst_banks_strip", 32'(u_strip.bank_full), 32'd0);
        check("rst_banks_full", 32'(u_full.bank_full), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        send_frame(rand_frame(), mk_res(1'b0, 3'd0, '0, '0), 8, 1'b0);
        wait_idle(2000);

        for (int f = 0; f < 8; f++) begin
            wait_pending(3000);
            repeat ($urandom_range(0, 20)) step();
            d = rand_frame();
            r.due  = 32'd0;
            r.fail = ($urandom_range(0, 7) == 0);
            r.num  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            for (int i = 0; i < 4; i++) begin
                r.el[i] = 8'($urandom_range(0, 255));
                r.ev[i] = 8'($urandom_range(1, 255));
            end
            send_frame(d, r, $urandom_range(1, 200), 1'b0);
        end
        wait_idle(4000);

        check("overflow_count_strip", 32'(ovf_seen[0]), 32'(exp_ovf));
        check("overflow_count_full", 32'(ovf_seen[1]), 32'(exp_ovf));
        check("end_banks_strip", 32'(u_strip.bank_full), 32'd0);
        check("end_banks_full", 32'(u_full.bank_full), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
